tea_cipher_engine: RTL
======================

// Module: tea_cipher_engine
// PURPOSE
//  Parametrised TEA/XTEA block-cipher engine: 64-bit block, 128-bit key, run-time algorithm and
//  direction select, UNROLL cycles (rounds) per clock. Valid/ready handshakes on data in/out;
//  key loaded as four 32-bit words through a separate write port. Sits between a host register
//  file and a streaming datapath.
// PARAMETERS
//  ROUNDS     32  cycles per block (each cycle = two Feistel half-rounds); must be multiple of UNROLL
//  UNROLL     1   cycles computed per clock: 1, 2, 4 or 8
//  SWAPBYTES  1   1: byte-swap each 32-bit word at in/out (little-endian words); 0: pass through
// PORTS
//  clk        in   1   clock
//  reset      in   1   synchronous, active-high reset
//  key_wr     in   1   write key word (honoured only when key_ready=1)
//  key_sel    in   2   key word index: 0=k0 .. 3=k3
//  key_word   in   32  key word data (byte-swapped if SWAPBYTES)
//  key_ready  out  1   1 when state != RUN
//  in_valid   in   1   block offered
//  in_ready   out  1   engine accepts block
//  in_data    in   64  block; [63:32]=v0, [31:0]=v1
//  in_decrypt in   1   0=encrypt, 1=decrypt; sampled with in_data
//  in_xtea    in   1   0=TEA, 1=XTEA; sampled with in_data
//  out_valid  out  1   result available
//  out_ready  in   1   consumer accepts result
//  out_data   out  64  result, same layout as in_data
// BEHAVIOUR
//  - Reset: state IDLE, k0..k3=0, v=0, sum=0, cnt=0; out_valid=0, in_ready=1, key_ready=1,
//    out_data=0. Reset mid-RUN aborts block; no out_valid follows.
//  - States: IDLE -(in_valid)-> RUN -(cnt==ROUNDS/UNROLL-1 step done)-> DONE
//    -(out_ready, no new accept)-> IDLE; DONE -(out_ready & in_valid)-> RUN (back-to-back).
//  - in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready:
//    latch v, decrypt, xtea; cnt<=0.
//  - Initial sum (mod 2^32, DELTA=0x9E3779B9): TEA enc: DELTA; TEA dec: ROUNDS*DELTA;
//    XTEA enc: 0; XTEA dec: ROUNDS*DELTA.
//  - TEA cycle, F(x,a,b)=((x<<4)+a)^(x+sum)^((x>>5)+b):
//    enc v0+=F(v1,k0,k1); v1+=F(v0,k2,k3); sum+=DELTA.
//    dec v1-=F(v0,k2,k3); v0-=F(v1,k0,k1); sum-=DELTA.
//  - XTEA cycle, G(x)=((x<<4)^(x>>5))+x:
//    enc v0+=G(v1)^(sum+k[sum[1:0]]); sum+=DELTA; v1+=G(v0)^(sum+k[sum[12:11]]).
//    dec v1-=G(v0)^(sum+k[sum[12:11]]); sum-=DELTA; v0-=G(v1)^(sum+k[sum[1:0]]).
//  - All arithmetic is 32-bit modulo 2^32; shifts are logical.
//  - RUN: each clock applies UNROLL chained cycles; cnt increments. Latency from accept edge to
//    out_valid=1 is exactly ROUNDS/UNROLL clocks.
//  - DONE: out_valid=1; out_data holds stable until out_ready is sampled high.
//  - key_wr when key_ready=0 is ignored (key never changes mid-block). key_wr and accept in the
//    same IDLE cycle: key updated at that edge; the new block uses the old key.
//  - in_decrypt/in_xtea/key changes outside accept have no effect on the block in flight.
// STRUCTURE
//  - tea_pkg: DELTA, byteswap32/byteswap32_64 functions, state enum (IDLE/RUN/DONE).
//  - Sub-module tea_cycle: combinational single cycle; inputs v, sum, key, decrypt, xtea;
//    outputs v_next, sum_next. Engine instantiates UNROLL copies in a generate chain.
//  - Engine holds FSM, counter, key regs and the I/O byte-swap.
// TESTING (SWAPBYTES=0 unless noted)
//  - TEA enc, key=0, in=0 -> out=0x41EA3A0A_94BAA940; out_valid exactly 32 clocks after accept.
//  - XTEA enc, key=0, in=0 -> out=0xDEE9D4D8_F7131ED9; repeat UNROLL=4: same data, latency 8.
//  - Random key/data, enc then dec for TEA and XTEA -> recovered plaintext equals input.
//  - out_ready held 0 for 10 clocks in DONE -> out_data stable, in_ready=0; then out_ready=1 with
//    in_valid=1 -> new block accepted same edge, next result after ROUNDS/UNROLL clocks.
//  - key_wr during RUN -> key_ready=0, write ignored, result matches old key.
//  - reset asserted at cycle 10 of RUN -> next clock IDLE, out_valid=0, key=0;
//    SWAPBYTES=1 run matches byte-swapped model.

Source files
------------

// File: rtl/tea_cipher_engine_pkg.sv
// ---------------------------------------------------------------------------
// tea_cipher_engine_pkg
//   Shared definitions for the TEA/XTEA engine: round constant, FSM state
//   encoding and small helpers for byte-swapping and key-word selection.
// ---------------------------------------------------------------------------
package tea_cipher_engine_pkg;

   localparam logic [31:0] DELTA = 32'h9E3779B9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic [31:0] byteswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   // Swaps bytes inside each 32-bit half; the half order itself is kept.
   function automatic logic [63:0] byteswap32_64(input logic [63:0] d);
      return {byteswap32(d[63:32]), byteswap32(d[31:0])};
   endfunction

   // Key is packed with k0 in the top word: {k0, k1, k2, k3}.
   function automatic logic [31:0] key_word(input logic [127:0] key, input logic [1:0] idx);
      logic [31:0] w;
      unique case (idx)
         2'd0:    w = key[127:96];
         2'd1:    w = key[95:64];
         2'd2:    w = key[63:32];
         default: w = key[31:0];
      endcase
      return w;
   endfunction

endpackage

// File: rtl/tea_cipher_engine_if.sv
// ---------------------------------------------------------------------------
// tea_cipher_engine_if
//   Bundles the block-in, block-out and key-write ports of the engine.
//   master: the host/stream side that offers blocks and keys.
//   slave : the engine.
//
//   Handshake rule (both data channels): a transfer happens on the rising
//   clock edge where valid and ready are both 1. The producer keeps valid
//   and its payload stable until that edge; ready may depend on the other
//   channel (in_ready rises in DONE when out_ready is high) but never on
//   in_valid. key_wr is a single-cycle write, honoured only while key_ready=1.
// ---------------------------------------------------------------------------
interface tea_cipher_engine_if;

   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;     // [63:32]=v0, [31:0]=v1
   logic        in_decrypt;
   logic        in_xtea;

   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;

   logic        key_wr;
   logic [1:0]  key_sel;
   logic [31:0] key_word;
   logic        key_ready;

   modport master (
      output in_valid, in_data, in_decrypt, in_xtea, out_ready,
             key_wr, key_sel, key_word,
      input  in_ready, out_valid, out_data, key_ready
   );

   modport slave (
      input  in_valid, in_data, in_decrypt, in_xtea, out_ready,
             key_wr, key_sel, key_word,
      output in_ready, out_valid, out_data, key_ready
   );

endinterface

// File: rtl/tea_cipher_engine_cycle.sv
// ---------------------------------------------------------------------------
// tea_cipher_engine_cycle
//   Purely combinational TEA/XTEA cycle (two Feistel half-rounds).
//   Ports:
//     v        in  64  current block {v0, v1}
//     sum      in  32  current round sum
//     key      in  128 {k0, k1, k2, k3}
//     decrypt  in  1   0=encrypt, 1=decrypt
//     xtea     in  1   0=TEA, 1=XTEA
//     v_next   out 64  block after this cycle
//     sum_next out 32  sum after this cycle
// ---------------------------------------------------------------------------
module tea_cipher_engine_cycle
   import tea_cipher_engine_pkg::*;
(
   input  logic [63:0]  v,
   input  logic [31:0]  sum,
   input  logic [127:0] key,
   input  logic         decrypt,
   input  logic         xtea,
   output logic [63:0]  v_next,
   output logic [31:0]  sum_next
);

   function automatic logic [31:0] tea_f(input logic [31:0] x, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] s);
      return ((x << 4) + a) ^ (x + s) ^ ((x >> 5) + b);
   endfunction

   function automatic logic [31:0] xtea_g(input logic [31:0] x);
      return ((x << 4) ^ (x >> 5)) + x;
   endfunction

   logic [31:0] v0, v1, v0_n, v1_n, s_mid;
   logic [31:0] k0, k1, k2, k3;

   assign v0 = v[63:32];
   assign v1 = v[31:0];
   assign k0 = key[127:96];
   assign k1 = key[95:64];
   assign k2 = key[63:32];
   assign k3 = key[31:0];

   always_comb begin
      v0_n     = v0;
      v1_n     = v1;
      s_mid    = sum;
      sum_next = sum;
      if (!xtea) begin
         if (!decrypt) begin
            v0_n     = v0 + tea_f(v1, k0, k1, sum);
            v1_n     = v1 + tea_f(v0_n, k2, k3, sum);
            sum_next = sum + DELTA;
         end else begin
            v1_n     = v1 - tea_f(v0, k2, k3, sum);
            v0_n     = v0 - tea_f(v1_n, k0, k1, sum);
            sum_next = sum - DELTA;
         end
      end else begin
         // XTEA updates sum between the halves; the second half uses the
         // updated sum for both its key index and its additive term.
         if (!decrypt) begin
            v0_n     = v0 + (xtea_g(v1) ^ (sum + key_word(key, sum[1:0])));
            s_mid    = sum + DELTA;
            v1_n     = v1 + (xtea_g(v0_n) ^ (s_mid + key_word(key, s_mid[12:11])));
            sum_next = s_mid;
         end else begin
            v1_n     = v1 - (xtea_g(v0) ^ (sum + key_word(key, sum[12:11])));
            s_mid    = sum - DELTA;
            v0_n     = v0 - (xtea_g(v1_n) ^ (s_mid + key_word(key, s_mid[1:0])));
            sum_next = s_mid;
         end
      end
      v_next = {v0_n, v1_n};
   end

endmodule

// File: rtl/tea_cipher_engine.sv
// ---------------------------------------------------------------------------
// tea_cipher_engine
//   TEA/XTEA block-cipher engine, 64-bit block, 128-bit key, algorithm and
//   direction chosen per block. UNROLL cipher cycles are chained per clock,
//   so a block takes ROUNDS/UNROLL clocks from accept to out_valid.
//   ROUNDS must be a multiple of UNROLL; UNROLL is 1, 2, 4 or 8.
//   Ports:
//     clk        in   clock
//     reset      in   synchronous, active-high reset
//     bus        slave modport of tea_cipher_engine_if (blocks in/out, key)
//     dbg_state  out  current FSM state
// ---------------------------------------------------------------------------
module tea_cipher_engine
   import tea_cipher_engine_pkg::*;
#(
   parameter int ROUNDS    = 32,
   parameter int UNROLL    = 1,
   parameter int SWAPBYTES = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   tea_cipher_engine_if.slave   bus,
   output state_e               dbg_state
);

   localparam int          STEPS    = ROUNDS / UNROLL;
   localparam int          CW       = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(STEPS - 1);
   localparam logic [31:0] SUM_DEC  = DELTA * 32'(ROUNDS);

   // TEA encrypt pre-loads DELTA because its cycle adds DELTA after use.
   function automatic logic [31:0] init_sum(input logic dec, input logic xt);
      logic [31:0] s;
      if (dec)     s = SUM_DEC;
      else if (xt) s = 32'h0;
      else         s = DELTA;
      return s;
   endfunction

   state_e          state_q, state_d;
   logic [127:0]    key_q, key_d;         // programmed key
   logic [127:0]    blk_key_q, blk_key_d; // key snapshot for the block in flight
   logic [63:0]     v_q, v_d;
   logic [31:0]     sum_q, sum_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            dec_q, dec_d;
   logic            xtea_q, xtea_d;
   logic            out_valid_q, out_valid_d;
   logic [63:0]     out_data_q, out_data_d;

   logic            in_ready;
   logic            accept;
   logic [63:0]     in_v;
   logic [31:0]     key_w;

   logic [63:0]     v_chain   [UNROLL+1];
   logic [31:0]     sum_chain [UNROLL+1];

   assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
   assign accept   = bus.in_valid && in_ready;
   assign in_v     = (SWAPBYTES != 0) ? byteswap32_64(bus.in_data) : bus.in_data;
   assign key_w    = (SWAPBYTES != 0) ? byteswap32(bus.key_word) : bus.key_word;

   assign v_chain[0]   = v_q;
   assign sum_chain[0] = sum_q;

   for (genvar i = 0; i < UNROLL; i++) begin : g_cycle
      tea_cipher_engine_cycle u_cycle (
         .v        (v_chain[i]),
         .sum      (sum_chain[i]),
         .key      (blk_key_q),
         .decrypt  (dec_q),
         .xtea     (xtea_q),
         .v_next   (v_chain[i+1]),
         .sum_next (sum_chain[i+1])
      );
   end

   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      blk_key_d   = blk_key_q;
      v_d         = v_q;
      sum_d       = sum_q;
      cnt_d       = cnt_q;
      dec_d       = dec_q;
      xtea_d      = xtea_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      if (bus.key_wr && (state_q != ST_RUN)) begin
         unique case (bus.key_sel)
            2'd0:    key_d[127:96] = key_w;
            2'd1:    key_d[95:64]  = key_w;
            2'd2:    key_d[63:32]  = key_w;
            default: key_d[31:0]   = key_w;
         endcase
      end

      unique case (state_q)
         ST_RUN: begin
            v_d   = v_chain[UNROLL];
            sum_d = sum_chain[UNROLL];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d     = ST_DONE;
               out_valid_d = 1'b1;
               out_data_d  = (SWAPBYTES != 0) ? byteswap32_64(v_chain[UNROLL])
                                              : v_chain[UNROLL];
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: ;
      endcase

      // Accept wins over the DONE->IDLE exit. blk_key takes key_q (the
      // pre-write value), so a key write in the accept cycle only affects
      // later blocks.
      if (accept) begin
         state_d   = ST_RUN;
         v_d       = in_v;
         sum_d     = init_sum(bus.in_decrypt, bus.in_xtea);
         cnt_d     = '0;
         dec_d     = bus.in_decrypt;
         xtea_d    = bus.in_xtea;
         blk_key_d = key_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         key_q       <= '0;
         blk_key_q   <= '0;
         v_q         <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         dec_q       <= 1'b0;
         xtea_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         blk_key_q   <= blk_key_d;
         v_q         <= v_d;
         sum_q       <= sum_d;
         cnt_q       <= cnt_d;
         dec_q       <= dec_d;
         xtea_q      <= xtea_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.key_ready = (state_q != ST_RUN);
   assign dbg_state     = state_q;

endmodule
